fetch_pc_unit: RTL

- Upstream neighbour of the fetch-stage instruction memory.
- The memory has a synchronous read (1-cycle latency); a flush zeroes its output register; flush takes priority over read enable.
- This block owns the PC register and drives the memory's pc, read_en and flush.
- It tracks which PC is in flight, so the IF/ID register receives an aligned (if_pc, if_valid) pair alongside the memory's instruction output.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the fetch PC unit.
//   fetch_state_t : fetch sequencing state (BOOT, RUN, HALT)
//   DEFAULT_RESET_PC : PC loaded on reset
//   DEFAULT_PC_STEP  : sequential increment (no compressed instructions)
//   NOP_INSTR        : value the instruction memory presents after a flush
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Owns the fetch PC, drives the synchronous instruction memory (pc, read
//   enable, flush) and tracks which PC is in flight so the IF/ID register sees
//   an aligned (if_pc, if_valid) pair next to the memory output.
//
//   state | meaning
//   BOOT  | loader owns instruction memory; no fetch until boot_hold drops
//   RUN   | fetching sequentially, honouring stall and redirect
//   HALT  | ecall/ebreak seen; idle until a redirect restarts fetch
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_boot_hold              loader busy; blocks fetch
//   i_stall                  hazard stall; freezes fetch
//   i_redirect_valid/target  taken branch/jump from execute
//   i_halt_req               stop fetching
//   o_imem_pc/read_en/flush  instruction memory controls
//   o_if_pc, o_if_pc_plus4   PC (and PC+4) of the instruction on memory output
//   o_if_valid               memory output is a real instruction
//   o_fetch_misaligned       1-cycle pulse: redirect target low bits nonzero
//   o_halted                 state is HALT
//   o_fetch_count            number of issued (non-flushed) fetches
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_boot_hold,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_halt_req,
    output logic [31:0] o_imem_pc,
    output logic        o_imem_read_en,
    output logic        o_imem_flush,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc_plus4,
    output logic        o_if_valid,
    output logic        o_fetch_misaligned,
    output logic        o_halted,
    output logic [31:0] o_fetch_count
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_if_pc;
    logic         r_if_valid;
    logic         r_misaligned;
    logic [31:0]  r_fetch_count;

    logic w_run;
    logic w_accept;
    logic w_read_en;
    logic w_flush;

    assign w_run     = (r_state == RUN);
    // Redirects are ignored while the loader still owns memory.
    assign w_accept  = (r_state != BOOT) && i_redirect_valid;
    assign w_read_en = w_run && !i_stall;
    assign w_flush   = w_accept || (w_run && i_halt_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_if_pc       <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_misaligned  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            case (r_state)
                BOOT: if (!i_boot_hold) r_state <= RUN;
                // The redirecting instruction is older than the halting one.
                RUN:  if (i_halt_req && !i_redirect_valid) r_state <= HALT;
                HALT: if (i_redirect_valid) r_state <= RUN;
                default: r_state <= BOOT;
            endcase

            if (w_accept) begin
                r_pc <= {i_redirect_target[31:2], 2'b00};
            end else if (w_read_en) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_flush) begin
                r_if_valid <= 1'b0;
            end else if (w_read_en) begin
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
            end else if (!w_run) begin
                r_if_valid <= 1'b0;
            end

            r_misaligned <= w_accept && (i_redirect_target[1:0] != 2'b00);

            if (w_read_en && !w_flush) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign o_imem_pc          = r_pc;
    assign o_imem_read_en     = w_read_en;
    assign o_imem_flush       = w_flush;
    assign o_if_pc            = r_if_pc;
    assign o_if_pc_plus4      = r_if_pc + 32'd4;
    assign o_if_valid         = r_if_valid;
    assign o_fetch_misaligned = r_misaligned;
    assign o_halted           = (r_state == HALT);
    assign o_fetch_count      = r_fetch_count;

endmodule
